// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants, FSM state type and rate derivation.
package sha3_pkg;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} pad_state_t;

  localparam logic [7:0] PAD_FINAL = 8'h80;
  localparam logic [7:0] DS_SHA3   = 8'h06;
  localparam logic [7:0] DS_SHAKE  = 8'h1F;

  // Rate in bits for lane exponent l and security parameter d (c = 2d).
  function automatic int rate_bits(input int l, input int d);
    return 25 * (2 ** l) - 2 * d;
  endfunction

  function automatic int rate_bytes(input int l, input int d);
    return rate_bits(l, d) / 8;
  endfunction

endpackage

// File: rtl/sha3_pad_insert.sv
// Combinational pad10*1 insertion: XOR the suffix at a byte position and
// the final 0x80 into the last rate byte. Both may hit the same byte.
module sha3_pad_insert
  import sha3_pkg::*;
#(
  parameter int R  = 172,
  parameter int CW = 8
) (
  input  logic [8*R-1:0] i_buf,
  input  logic [CW-1:0]  i_pos,
  input  logic [7:0]     i_ds,
  output logic [8*R-1:0] o_buf
);

  // Suffix first, then final bit; XOR keeps the 0x86 overlap case correct.
  always_comb begin
    o_buf = i_buf;
    o_buf[8*i_pos +: 8] = o_buf[8*i_pos +: 8] ^ i_ds;
    o_buf[8*R-8 +: 8]   = o_buf[8*R-8 +: 8] ^ PAD_FINAL;
  end

endmodule

// File: rtl/sha3_padder.sv
// Byte-stream to rate-block assembler with SHA-3 padding, feeding the
// keccak absorb port over a valid/ready handshake.
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int         l  = 6,
  parameter int         d  = 112,
  parameter logic [7:0] DS = DS_SHA3,
  localparam int        r  = rate_bits(l, d),
  localparam int        R  = r / 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_keep,
  output logic         in_ready,
  output logic [r-1:0] block,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready
);

  localparam int            CW       = $clog2(R);
  localparam logic [CW-1:0] LAST_IDX = CW'(R - 1);

  if (r % 8 != 0) begin : g_rate_check
    $error("sha3_padder: rate must be a whole number of bytes");
  end

  pad_state_t    r_state;
  logic [r-1:0]  r_buf;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_last;

  logic          w_acc;
  logic [r-1:0]  w_wr;
  logic [CW-1:0] w_pos;
  logic [r-1:0]  w_tail;
  logic [r-1:0]  w_padonly;

  assign in_ready    = (r_state == FILL);
  assign block_valid = (r_state == EMIT);
  assign block       = r_buf;
  assign block_last  = r_last;
  assign w_acc       = in_valid & in_ready;

  // Buffer with the incoming byte merged at the current index.
  always_comb begin
    w_wr = r_buf;
    if (in_keep) w_wr[8*r_cnt +: 8] = in_data;
  end

  // Suffix lands after the byte just written, or at cnt for an empty tail.
  assign w_pos = in_keep ? r_cnt + CW'(1) : r_cnt;

  sha3_pad_insert #(.R(R), .CW(CW)) u_pad_tail (
    .i_buf (w_wr),
    .i_pos (w_pos),
    .i_ds  (DS),
    .o_buf (w_tail)
  );

  // Pad-only block for a message that ended exactly on a block boundary.
  sha3_pad_insert #(.R(R), .CW(CW)) u_pad_only (
    .i_buf ('0),
    .i_pos ('0),
    .i_ds  (DS),
    .o_buf (w_padonly)
  );

  // Fill/emit control: byte assembly, padding decisions and block handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_acc) begin
            if (in_last) begin
              r_state <= EMIT;
              r_cnt   <= '0;
              if (in_keep && r_cnt == LAST_IDX) begin
                // Block full with message; padding needs a block of its own.
                r_buf  <= w_wr;
                r_last <= 1'b0;
                r_pend <= 1'b1;
              end else begin
                r_buf  <= w_tail;
                r_last <= 1'b1;
              end
            end else if (in_keep) begin
              r_buf <= w_wr;
              if (r_cnt == LAST_IDX) begin
                r_cnt   <= '0;
                r_state <= EMIT;
                r_last  <= 1'b0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
        end
        EMIT: begin
          if (block_ready) begin
            if (r_pend) begin
              r_buf  <= w_padonly;
              r_last <= 1'b1;
              r_pend <= 1'b0;
            end else begin
              r_buf   <= '0;
              r_last  <= 1'b0;
              r_cnt   <= '0;
              r_state <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // A beat without data must be the message tail.
  a_keep_only_on_last: assert property (
    @(posedge clk) disable iff (reset) in_valid |-> (in_keep || in_last));

endmodule

// File: tb/tb_sha3_padder.sv
// Randomized bench for sha3_padder against a byte-array padding model.
module tb_sha3_padder;

  localparam int R  = 172;
  localparam int RB = 8 * R;
  localparam logic [7:0] DSB = 8'h06;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_keep = 1'b1;
  logic          in_ready;
  logic [RB-1:0] block;
  logic          block_valid;
  logic          block_last;
  logic          block_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0]    msg[$];
  logic [RB-1:0] exp_blk[$];
  logic          exp_lst[$];

  sha3_padder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_keep(in_keep), .in_ready(in_ready),
    .block(block), .block_valid(block_valid), .block_last(block_last),
    .block_ready(block_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
    int idx;
    checks++;
    assert (got === exp) else begin
      failures++;
      idx = -1;
      for (int j = 0; j < R; j++)
        if (idx < 0 && got[8*j +: 8] !== exp[8*j +: 8]) idx = j;
      $error("FAIL %s first bad byte %0d got=%h expected=%h", tag, idx,
             got[8*idx +: 8], exp[8*idx +: 8]);
    end
  endtask

  // Reference: padded length = whole blocks covering msg plus one suffix byte.
  task automatic build_exp();
    int n, nblk;
    logic [7:0] pad[];
    logic [RB-1:0] b;
    n = msg.size();
    nblk = n / R + 1;
    pad = new[nblk * R];
    foreach (pad[i]) pad[i] = 8'h00;
    for (int i = 0; i < n; i++) pad[i] = msg[i];
    pad[n] = pad[n] ^ DSB;
    pad[nblk*R-1] = pad[nblk*R-1] ^ 8'h80;
    exp_blk.delete();
    exp_lst.delete();
    for (int k = 0; k < nblk; k++) begin
      for (int j = 0; j < R; j++) b[8*j +: 8] = pad[k*R + j];
      exp_blk.push_back(b);
      exp_lst.push_back(k == nblk - 1);
    end
  endtask

  task automatic make_msg(input int n, input bit rnd, input logic [7:0] fill);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(rnd ? 8'($urandom) : fill);
  endtask

  // Drive msg (optionally with a separate keep=0 tail beat), consume blocks
  // with `hold` stall cycles each, and check every block and handshake rule.
  task automatic run_msg(input bit tail0, input int hold, input bit gaps, input int abort_at);
    int n, beats, sent, got, cyc, wait_left, in_blk;
    bit seen, prev_cmpl, acc, hs;
    logic [RB-1:0] snap;
    logic snap_last;
    n = msg.size();
    if (n == 0) tail0 = 1'b1;
    beats = tail0 ? n + 1 : n;
    build_exp();
    sent = 0; got = 0; cyc = 0; wait_left = 0; in_blk = 0;
    seen = 0; prev_cmpl = 0;
    while (got < exp_blk.size() && cyc < 5000 && !(abort_at >= 0 && sent >= abort_at)) begin
      @(negedge clk);
      cyc++;
      if (prev_cmpl) chk("latency", block_valid, 1);
      chk("excl", in_ready & block_valid, 0);
      if (block_valid) begin
        if (!seen) begin
          seen = 1; snap = block; snap_last = block_last; wait_left = hold;
        end else begin
          chk_blk("hold_blk", block, snap);
          chk("hold_last", block_last, snap_last);
          chk("hold_rdy", in_ready, 0);
        end
      end
      if (block_valid) begin
        block_ready = (wait_left == 0);
        if (wait_left > 0) wait_left--;
      end else block_ready = 1'($urandom);
      if (sent < beats && (!gaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_keep  = (sent < n);
        in_data  = (sent < n) ? msg[sent] : 8'($urandom);
        in_last  = (sent == beats - 1);
      end else begin
        in_valid = 1'b0; in_keep = 1'b1; in_last = 1'b0; in_data = 8'($urandom);
      end
      acc = in_valid & in_ready;
      hs  = block_valid & block_ready;
      prev_cmpl = 0;
      if (acc) begin
        sent++;
        if (in_keep) in_blk++;
        prev_cmpl = (in_blk == R) || in_last;
        if (in_blk == R || in_last) in_blk = 0;
      end
      if (hs) begin
        chk_blk("blk", block, exp_blk[got]);
        chk("blk_last", block_last, exp_lst[got]);
        got++;
        seen = 0;
      end
    end
    if (cyc >= 5000) begin
      failures++;
      $display("FAIL timeout got=%0d blocks expected=%0d", got, exp_blk.size());
    end
    if (abort_at < 0) begin
      @(negedge clk);
      in_valid = 1'b0; block_ready = 1'b0;
      chk("no_extra_blk", block_valid, 0);
      chk("rdy_after", in_ready, 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", block_valid, 0);
    chk("rst_last", block_last, 0);
    chk_blk("rst_blk", block, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    // empty message
    make_msg(0, 0, 8'h00);            run_msg(1, 0, 0, -1);
    // "abc"
    msg = '{8'h61, 8'h62, 8'h63};     run_msg(0, 0, 0, -1);
    // 171 x A5: suffix and final bit share the last byte
    make_msg(171, 0, 8'hA5);          run_msg(0, 1, 0, -1);
    // 172 x 00: exactly two blocks
    make_msg(172, 0, 8'h00);          run_msg(0, 0, 0, -1);
    // 344 bytes with 5-cycle stalls
    make_msg(344, 1, 8'h00);          run_msg(0, 5, 1, -1);
    // random lengths, tail styles and stalls
    for (int t = 0; t < 4; t++) begin
      make_msg($urandom_range(0, 400), 1, 8'h00);
      run_msg(1'($urandom), $urandom_range(0, 3), 1, -1);
    end

    // async reset mid-message
    make_msg(100, 1, 8'h00);
    run_msg(0, 0, 0, 50);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", block_valid, 0);
    chk("mid_rst_last", block_last, 0);
    chk_blk("mid_rst_blk", block, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_idle", block_valid, 0);
    msg = '{8'h61, 8'h62, 8'h63};     run_msg(0, 2, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
